regbank_banco_multiport: RTL

Parametrised successor to the single-write, dual-read MIPS register bank. It adds N combinational read ports, synchronous active-low clear, a hardwired zero register, and a per-register busy scoreboard for pipeline hazard detection. It sits between the decode stage (reads, reservations) and the writeback stage (writes, busy release).

---
 rtl/regbank_pkg.sv | 19 +
 rtl/regbank_scoreboard.sv | 28 ++
 rtl/regbank_banco_multiport.sv | 77 +++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and bus-slicing helper for the multiport register bank.
package regbank_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int ZERO_IDX    = 0;
  localparam int MAX_SLICE_W = 64;
  localparam int MAX_PORTS   = 4;
  localparam int MAX_BUS_W   = MAX_PORTS * MAX_SLICE_W;

  // Returns field k of width w from a flattened bus; caller truncates to w.
  function automatic logic [MAX_SLICE_W-1:0] getSlice(input logic [MAX_BUS_W-1:0] bus,
                                                      input int k, input int w);
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (k * w);
    return shifted[MAX_SLICE_W-1:0];
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register busy bits: a reservation sets, a writeback clears, set wins on collision.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 setEn,
  input  logic [ADDR_W-1:0]    setIdx,
  input  logic                 clrEn,
  input  logic [ADDR_W-1:0]    clrIdx,
  output logic [2**ADDR_W-1:0] busy
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrIdx] <= 1'b0;
      // Applied after the clear so a new producer supersedes the retiring one.
      if (setEn) busy[setIdx] <= 1'b1;
      if (ZERO_REG != 0) busy[ZERO_IDX] <= 1'b0;
    end
  end

endmodule

// File: rtl/regbank_banco_multiport.sv
// Multiport register bank with busy scoreboard and optional zero register.
// Optional write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module regbank_banco_multiport
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       regWrite,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic [DATA_W-1:0]          writeData,
  input  logic [NUM_READ*ADDR_W-1:0] readReg,
  output logic [NUM_READ*DATA_W-1:0] readData,
  output logic [NUM_READ-1:0]        readBusy,
  input  logic                       reserveEn,
  input  logic [ADDR_W-1:0]          reserveReg,
  output logic                       anyBusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busyVec;
  logic [ADDR_W-1:0] idx;
  logic              isZero;
  logic              writeToZero;

  assign writeToZero = (ZERO_REG != 0) && (writeReg == ADDR_W'(ZERO_IDX));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (regWrite && !writeToZero) begin
      mem[writeReg] <= writeData;
    end
  end

  regbank_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .setEn   (reserveEn),
    .setIdx  (reserveReg),
    .clrEn   (regWrite),
    .clrIdx  (writeReg),
    .busy    (busyVec)
  );

  assign anyBusy = |busyVec;

  always_comb begin
    readData = '0;
    readBusy = '0;
    idx      = '0;
    isZero   = 1'b0;
    for (int k = 0; k < NUM_READ; k++) begin
      idx    = ADDR_W'(getSlice(MAX_BUS_W'(readReg), k, ADDR_W));
      isZero = (ZERO_REG != 0) && (idx == ADDR_W'(ZERO_IDX));
      readData[k*DATA_W +: DATA_W] = isZero ? '0 : mem[idx];
      readBusy[k] = busyVec[idx];
`ifdef REGBANK_BYPASS_EN
      // Forward only when no new producer is claiming the same register this cycle.
      if (regWrite && (writeReg == idx) && !isZero && !(reserveEn && (reserveReg == idx))) begin
        readData[k*DATA_W +: DATA_W] = writeData;
        readBusy[k] = 1'b0;
      end
`endif
    end
  end

endmodule
